// File: rtl/taito_palette_dar.sv
// Palette lookup and RGB output stage with 68000 access to a single-port palette RAM.
// Video lookups use pixel-enable slots and CPU accesses use the remaining 13 MHz slots.
module taito_palette_dar #(
   parameter int IDX_W  = 13,
   parameter int SS_IDX = -1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce_13m,
   input  logic             ce_pixel,
   input  logic [IDX_W-1:0] color_in,
   input  logic             hblank_n,
   input  logic             vblank_n,
   input  logic [IDX_W-1:0] cpu_addr,
   input  logic [15:0]      cpu_din,
   output logic [15:0]      cpu_dout,
   input  logic             cpu_cs_n,
   input  logic             cpu_uds_n,
   input  logic             cpu_lds_n,
   input  logic             cpu_rw,
   output logic             dtack_n,
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue,
   output logic             hblank_out_n,
   output logic             vblank_out_n
);

   // state  | meaning
   // S_IDLE | waiting for a cpu_cs_n falling edge
   // S_WAIT | request latched, waiting for a CPU RAM slot
   // S_DATA | RAM access done, acknowledge on next ce_13m
   // S_ACK  | dtack held low until chip select is released
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_ACK} state_t;

   state_t state, state_nx;

   // Save-state hookup is reserved for this block.
   if (SS_IDX >= 0) begin : g_ss_reserved
   end

   logic             cpu_slot;
   logic             cs_prev;
   logic             cs_fall;
   logic [IDX_W-1:0] lat_addr;
   logic [15:0]      lat_din;
   logic [1:0]       lat_be;
   logic             lat_rw;
   logic             dtack_r;

   logic [15:0]      mem [2**IDX_W];
   logic [IDX_W-1:0] ram_addr;
   logic             ram_en;
   logic             ram_we;
   logic [15:0]      ram_q;

   logic             vid_pend;
   logic [14:0]      vid_q;
   logic [1:0]       blank_cap;

   function automatic logic [7:0] exp5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   assign cpu_slot = ce_13m & ~ce_pixel;
   assign cs_fall  = ce_13m & ~cpu_cs_n & cs_prev;
   assign dtack_n  = dtack_r | cpu_cs_n;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (cs_fall) state_nx = S_WAIT;
         S_WAIT:  if (cpu_slot) state_nx = S_DATA;
         S_DATA:  if (ce_13m) state_nx = cpu_cs_n ? S_IDLE : S_ACK;
         S_ACK:   if (ce_13m && cpu_cs_n) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cs_prev  <= 1'b1;
         dtack_r  <= 1'b1;
         cpu_dout <= '0;
         lat_addr <= '0;
         lat_din  <= '0;
         lat_be   <= '0;
         lat_rw   <= 1'b1;
      end else begin
         state <= state_nx;
         if (ce_13m) cs_prev <= cpu_cs_n;
         if (state == S_IDLE && cs_fall) begin
            lat_addr <= cpu_addr;
            lat_din  <= cpu_din;
            lat_be   <= {~cpu_uds_n, ~cpu_lds_n};
            lat_rw   <= cpu_rw;
         end
         if (state == S_DATA && ce_13m && !cpu_cs_n) begin
            dtack_r <= 1'b0;
            if (lat_rw) cpu_dout <= ram_q;
         end
         if (state == S_ACK && ce_13m && cpu_cs_n) dtack_r <= 1'b1;
      end
   end

   // Single RAM port: pixel slots own the address, CPU gets it only in its own slot.
   always_comb begin
      ram_addr = color_in;
      ram_en   = ce_pixel;
      ram_we   = 1'b0;
      if (state == S_WAIT && cpu_slot && !reset) begin
         ram_addr = lat_addr;
         ram_en   = 1'b1;
         ram_we   = ~lat_rw;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_en) begin
         if (ram_we && lat_be[1]) mem[ram_addr][15:8] <= lat_din[15:8];
         if (ram_we && lat_be[0]) mem[ram_addr][7:0]  <= lat_din[7:0];
         ram_q <= mem[ram_addr];
      end
   end

   // ram_q is moved into vid_q right after a pixel read, so CPU reads in between cannot clobber it.
   always_ff @(posedge clk) begin
      if (reset) begin
         vid_pend     <= 1'b0;
         vid_q        <= '0;
         blank_cap    <= 2'b00;
         red          <= '0;
         green        <= '0;
         blue         <= '0;
         hblank_out_n <= 1'b0;
         vblank_out_n <= 1'b0;
      end else begin
         vid_pend <= ce_pixel;
         if (vid_pend) vid_q <= ram_q[14:0];
         if (ce_pixel) begin
            blank_cap    <= {hblank_n, vblank_n};
            hblank_out_n <= blank_cap[1];
            vblank_out_n <= blank_cap[0];
            if (&blank_cap) begin
               red   <= exp5(vid_q[4:0]);
               green <= exp5(vid_q[9:5]);
               blue  <= exp5(vid_q[14:10]);
            end else begin
               red   <= '0;
               green <= '0;
               blue  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_taito_palette_dar.sv
// Randomized bench for taito_palette_dar: palette contents and pixel stream tracked by a
// behavioural model, checked every cycle, plus directed CPU-bus scenarios.
module tb_taito_palette_dar;
   localparam int IDX_W = 13;

   logic clk = 0, reset = 1, ce_13m = 0, ce_pixel = 0;
   logic [IDX_W-1:0] color_in = '0, cpu_addr = '0;
   logic hblank_n = 0, vblank_n = 0;
   logic [15:0] cpu_din = '0, cpu_dout;
   logic cpu_cs_n = 1, cpu_uds_n = 1, cpu_lds_n = 1, cpu_rw = 1;
   logic dtack_n, hblank_out_n, vblank_out_n;
   logic [7:0] red, green, blue;

   taito_palette_dar #(.IDX_W(IDX_W), .SS_IDX(-1)) dut (
      .clk(clk), .reset(reset), .ce_13m(ce_13m), .ce_pixel(ce_pixel),
      .color_in(color_in), .hblank_n(hblank_n), .vblank_n(vblank_n),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .cpu_cs_n(cpu_cs_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw),
      .dtack_n(dtack_n), .red(red), .green(green), .blue(blue),
      .hblank_out_n(hblank_out_n), .vblank_out_n(vblank_out_n));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int ce_cnt = 0, pix_cnt = 0;
   bit chk_en = 0;

   logic [15:0] mdl_mem [64];
   bit          m_cs_prev = 1, m_pend = 0;
   logic [5:0]  m_waddr;
   logic [15:0] m_wdin;
   logic [1:0]  m_wbe;
   logic [23:0] exp_rgb_cur = '0, exp_rgb_nxt = '0;
   logic [1:0]  exp_blk_cur = '0, exp_blk_nxt = '0;

   bit ce_manual = 0, last_pix = 0;
   int vid_mode = 0;
   logic [5:0] vid_fix = '0;
   logic [1:0] vid_blk = 2'b11;

   function automatic logic [23:0] pix(input logic [15:0] w, input logic [1:0] blk);
      int r, g, b;
      if (blk != 2'b11) return 24'd0;
      r = int'(w) % 32;
      g = (int'(w) / 32) % 32;
      b = (int'(w) / 1024) % 32;
      r = r * 8 + r / 4;
      g = g * 8 + g / 4;
      b = b * 8 + b / 4;
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: palette contents, CPU write commit point and one-pixel output delay.
   always @(posedge clk) begin
      if (ce_13m) ce_cnt++;
      if (ce_pixel) pix_cnt++;
      if (reset) begin
         m_pend = 0; m_cs_prev = 1;
         exp_rgb_cur = '0; exp_rgb_nxt = '0;
         exp_blk_cur = '0; exp_blk_nxt = '0;
      end else begin
         if (m_pend && ce_13m && !ce_pixel) begin
            logic [15:0] mask;
            mask = (m_wbe[1] ? 16'hFF00 : 16'h0000) | (m_wbe[0] ? 16'h00FF : 16'h0000);
            mdl_mem[m_waddr] = (mdl_mem[m_waddr] & ~mask) | (m_wdin & mask);
            m_pend = 0;
         end
         if (ce_13m) begin
            if (!cpu_cs_n && m_cs_prev && !cpu_rw) begin
               m_pend = 1; m_waddr = cpu_addr[5:0]; m_wdin = cpu_din;
               m_wbe = {~cpu_uds_n, ~cpu_lds_n};
            end
            m_cs_prev = cpu_cs_n;
         end
         if (ce_pixel) begin
            exp_rgb_cur = exp_rgb_nxt;
            exp_blk_cur = exp_blk_nxt;
            exp_blk_nxt = {hblank_n, vblank_n};
            exp_rgb_nxt = pix(mdl_mem[color_in[5:0]], exp_blk_nxt);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("pixel_rgb", {8'd0, red, green, blue}, {8'd0, exp_rgb_cur});
         check("pixel_blank", {30'd0, hblank_out_n, vblank_out_n}, {30'd0, exp_blk_cur});
      end
   end

   // Clock enables: ce_pixel is a subset of ce_13m and never on two ce_13m cycles in a row.
   always @(negedge clk) begin
      if (!ce_manual) begin
         ce_13m   = ($urandom_range(0, 2) != 0);
         ce_pixel = ce_13m && !last_pix && ($urandom_range(0, 1) == 1);
         if (ce_13m) last_pix = ce_pixel;
      end
   end

   always @(negedge clk) begin
      case (vid_mode)
         0: begin color_in = IDX_W'($urandom_range(0, 63)); hblank_n = 0; vblank_n = 0; end
         1: begin
            color_in = IDX_W'($urandom_range(0, 63));
            hblank_n = ($urandom_range(0, 7) != 0);
            vblank_n = ($urandom_range(0, 15) != 0);
         end
         default: begin color_in = IDX_W'(vid_fix); {hblank_n, vblank_n} = vid_blk; end
      endcase
   end

   task automatic cpu_access(input logic rw, input logic [5:0] addr, input logic [15:0] din,
                             input logic uds_n, input logic lds_n, output logic [15:0] dout);
      int start, c0;
      bit got;
      @(negedge clk); #1;
      cpu_addr = IDX_W'(addr); cpu_din = din; cpu_rw = rw;
      cpu_uds_n = uds_n; cpu_lds_n = lds_n; cpu_cs_n = 0;
      start = ce_cnt;
      got = 0;
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge clk); #1;
         if (!dtack_n) got = 1;
      end
      dout = cpu_dout;
      if (!got) check("dtack_timeout", 32'd1, 32'd0);
      else check("dtack_within_4", {31'd0, (ce_cnt - start) <= 4}, 32'd1);
      cpu_cs_n = 1;
      @(negedge clk); #1;
      check("dtack_release", {31'd0, dtack_n}, 32'd1);
      c0 = ce_cnt;
      for (int i = 0; i < 40 && ce_cnt < c0 + 2; i++) @(negedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [5:0] addr, input logic [15:0] din,
                            input logic uds_n, input logic lds_n);
      logic [15:0] d;
      cpu_access(1'b0, addr, din, uds_n, lds_n, d);
   endtask

   task automatic cpu_read_chk(input logic [5:0] addr);
      logic [15:0] d;
      cpu_access(1'b1, addr, 16'h0, 1'b0, 1'b0, d);
      check("read_vs_model", {16'd0, d}, {16'd0, mdl_mem[addr]});
   endtask

   task automatic cpu_read(input logic [5:0] addr, output logic [15:0] d);
      cpu_access(1'b1, addr, 16'h0, 1'b0, 1'b0, d);
   endtask

   task automatic wait_pix(input int n);
      int p0;
      p0 = pix_cnt;
      for (int i = 0; i < 400 && pix_cnt < p0 + n; i++) @(negedge clk);
      if (pix_cnt < p0 + n) check("pixel_timeout", 32'd1, 32'd0);
      #1;
   endtask

   initial begin
      logic [15:0] d, keep;
      for (int i = 0; i < 64; i++) mdl_mem[i] = 16'h0000;
      reset = 1;
      repeat (4) @(negedge clk);
      #1;
      check("reset_rgb", {8'd0, red, green, blue}, 32'd0);
      check("reset_dtack", {31'd0, dtack_n}, 32'd1);
      check("reset_dout", {16'd0, cpu_dout}, 32'd0);
      check("reset_blank", {30'd0, hblank_out_n, vblank_out_n}, 32'd0);
      reset = 0;
      chk_en = 1;

      cpu_write(6'h10, 16'h7FFF, 0, 0);
      cpu_read(6'h10, d);
      check("readback_7fff", {16'd0, d}, 32'h7FFF);
      cpu_write(6'h11, 16'h001F, 0, 0);
      cpu_write(6'h12, 16'h0010, 0, 0);
      for (int i = 0; i < 64; i++)
         if (i < 16 || i > 18) cpu_write(6'(i), 16'($urandom), 0, 0);

      vid_mode = 2; vid_blk = 2'b11;
      vid_fix = 6'h10; wait_pix(3);
      check("white_pixel", {8'd0, red, green, blue}, 32'hFFFFFF);
      vid_fix = 6'h11; wait_pix(3);
      check("red_pixel", {8'd0, red, green, blue}, 32'hFF0000);
      vid_fix = 6'h12; wait_pix(3);
      check("red_84", {8'd0, red, green, blue}, 32'h840000);

      cpu_write(6'h10, 16'hAB12, 1, 0);
      cpu_read(6'h10, d);
      check("byte_write", {16'd0, d}, 32'h7F12);

      vid_fix = 6'h10; vid_blk = 2'b01; wait_pix(3);
      check("hblank_rgb", {8'd0, red, green, blue}, 32'd0);
      check("hblank_out", {30'd0, hblank_out_n, vblank_out_n}, 32'h1);
      vid_blk = 2'b11;

      cpu_read(6'h13, keep);
      cpu_write(6'h13, ~keep, 1, 1);
      cpu_read(6'h13, d);
      check("no_strobe_write", {16'd0, d}, {16'd0, keep});

      vid_fix = 6'h20;
      for (int i = 0; i < 20; i++) cpu_write(6'h20, 16'($urandom), 0, 0);
      cpu_read_chk(6'h20);

      // Chip select dropped before acknowledge: write still lands, no dtack.
      @(negedge clk); #1;
      ce_manual = 1; ce_13m = 0; ce_pixel = 0;
      @(negedge clk); #1;
      keep = 16'($urandom);
      cpu_addr = IDX_W'(6'h14); cpu_din = keep; cpu_rw = 0;
      cpu_uds_n = 0; cpu_lds_n = 0; cpu_cs_n = 0; ce_13m = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         cpu_cs_n = 1;
         check("abort_no_dtack", {31'd0, dtack_n}, 32'd1);
      end
      ce_manual = 0;
      cpu_read(6'h14, d);
      check("abort_write_commits", {16'd0, d}, {16'd0, keep});

      // Reset while the write waits for its RAM slot.
      cpu_write(6'h30, 16'h5555, 0, 0);
      @(negedge clk); #1;
      ce_manual = 1; ce_13m = 0; ce_pixel = 0;
      @(negedge clk); #1;
      cpu_addr = IDX_W'(6'h30); cpu_din = 16'h1234; cpu_rw = 0;
      cpu_uds_n = 0; cpu_lds_n = 0; cpu_cs_n = 0; ce_13m = 1;
      @(negedge clk); #1;
      reset = 1;
      @(negedge clk); #1;
      check("reset_wait_dtack", {31'd0, dtack_n}, 32'd1);
      reset = 0; cpu_cs_n = 1; ce_13m = 0;
      @(negedge clk); #1;
      ce_manual = 0;
      cpu_read(6'h30, d);
      check("reset_wait_discard", {16'd0, d}, 32'h5555);

      vid_mode = 1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 1) == 1)
            cpu_read_chk(6'($urandom_range(0, 63)));
         else
            cpu_write(6'($urandom_range(0, 63)), 16'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      repeat (20) @(negedge clk);
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
